// File: rtl/iact_csc_read_ctrl_if.sv
// Data-spad read request bus from the iact CSC read sequencer to the data spad / MAC pipe.
// Plain valid/ready: the master holds every field stable while rd_valid && !rd_ready.
interface iact_csc_read_ctrl_if #(
    parameter int IDX_WIDTH = 4,
    parameter int COL_WIDTH = 4
);
    logic                 rd_valid;
    logic                 rd_ready;
    logic [IDX_WIDTH-1:0] rd_idx;
    logic [COL_WIDTH-1:0] rd_col;
    logic                 rd_col_last;

    modport master (
        output rd_valid,
        output rd_idx,
        output rd_col,
        output rd_col_last,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_idx,
        input  rd_col,
        input  rd_col_last,
        output rd_ready
    );
endinterface

// File: rtl/iact_csc_read_ctrl.sv
// Walks a CSC iact address spad and emits one data-spad read index per cycle, column by column.
// Latency: start to first rd_valid is 2 cycles; 1 bubble per column boundary, 1 cycle per empty column.
// Backpressure: rd_ready low freezes the request; addr_index_inc only fires on an accepted column end.
module iact_csc_read_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int IDX_WIDTH  = 4,
    parameter int COL_WIDTH  = 4,
    parameter int MAX_COLS   = 11
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] addr_data,
    output logic                  addr_index_inc,
    iact_csc_read_ctrl_if.master  rd,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_STREAM,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0]  SPAD_DEPTH = (ADDR_WIDTH+1)'(2 ** IDX_WIDTH);
    localparam logic [COL_WIDTH-1:0] COL_LIMIT  = COL_WIDTH'(MAX_COLS);

    state_t                state;
    logic [ADDR_WIDTH-1:0] cur_ptr;
    logic [ADDR_WIDTH-1:0] end_ptr;
    logic [COL_WIDTH-1:0]  col;

    logic fetch_term;
    logic fetch_bad;
    logic fetch_empty;
    logic col_last;

    assign fetch_term  = (addr_data == '0);
    // A pointer that moves backwards, overruns the data spad, or a 12th column means a corrupt spad.
    assign fetch_bad   = (addr_data < cur_ptr) || ({1'b0, addr_data} > SPAD_DEPTH) || (col == COL_LIMIT);
    assign fetch_empty = (addr_data == cur_ptr);
    assign col_last    = ((cur_ptr + ADDR_WIDTH'(1)) == end_ptr);

    // The spad advances on the edge ending this cycle, so the next FETCH sees the following entry.
    always_comb begin
        addr_index_inc = 1'b0;
        case (state)
            S_FETCH:  addr_index_inc = fetch_term || (!fetch_bad && fetch_empty);
            S_STREAM: addr_index_inc = rd.rd_ready && col_last;
            default:  addr_index_inc = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            cur_ptr <= '0;
            end_ptr <= '0;
            col     <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_FETCH;
                        err     <= 1'b0;
                        cur_ptr <= '0;
                        col     <= '0;
                    end
                end
                S_FETCH: begin
                    if (fetch_term) begin
                        state <= S_DONE;
                    end else if (fetch_bad) begin
                        err   <= 1'b1;
                        state <= S_DONE;
                    end else if (fetch_empty) begin
                        col <= col + COL_WIDTH'(1);
                    end else begin
                        end_ptr <= addr_data;
                        state   <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (rd.rd_ready) begin
                        cur_ptr <= cur_ptr + ADDR_WIDTH'(1);
                        if (col_last) begin
                            col   <= col + COL_WIDTH'(1);
                            state <= S_FETCH;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign rd.rd_valid    = (state == S_STREAM);
    assign rd.rd_idx      = cur_ptr[IDX_WIDTH-1:0];
    assign rd.rd_col      = col;
    assign rd.rd_col_last = (state == S_STREAM) && col_last;
    assign busy           = (state == S_FETCH) || (state == S_STREAM);
    assign done           = (state == S_DONE);
endmodule

// File: tb/tb_iact_csc_read_ctrl.sv
// Directed bench for iact_csc_read_ctrl with a behavioural address spad that rewinds on its terminator.
module tb_iact_csc_read_ctrl;
    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] addr_data;
    logic       addr_index_inc;
    logic       busy;
    logic       done;
    logic       err;

    iact_csc_read_ctrl_if #(.IDX_WIDTH(4), .COL_WIDTH(4)) rd_if ();

    iact_csc_read_ctrl #(
        .ADDR_WIDTH(8),
        .IDX_WIDTH (4),
        .COL_WIDTH (4),
        .MAX_COLS  (11)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .addr_data     (addr_data),
        .addr_index_inc(addr_index_inc),
        .rd            (rd_if.master),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clock = ~clock;

    // Address spad model: index_inc advances, and the inc on a zero entry rewinds to 0.
    logic [7:0] spad_mem [0:11];
    logic [3:0] sidx;
    logic       spad_rewind;
    always @(posedge clock) begin
        if (reset || spad_rewind) sidx <= 4'd0;
        else if (addr_index_inc) sidx <= (spad_mem[sidx] == 8'd0) ? 4'd0 : sidx + 4'd1;
    end
    assign addr_data = spad_mem[sidx];

    int errors = 0;
    int checks = 0;

    int rd_idx_q [$];
    int rd_col_q [$];
    int rd_last_q[$];
    int rd_cyc_q [$];
    int inc_cnt, done_cnt, done_cyc, post_valid, post_busy;
    logic err_end, err_c1;
    bit stall_ok, timed_out;

    task automatic clear_spad();
        for (int i = 0; i < 12; i++) spad_mem[i] = 8'd0;
    endtask

    // One pass: start in cycle 0, optional stall on one index, optional extra start pulse; 3 cycles observed after done.
    task automatic run_pass(input int stall_idx, input int stall_n, input int spur_cyc);
        bit seen_done = 0;
        bit prev_stalled = 0;
        int post_n = 0;
        int s_idx = 0, s_col = 0, s_last = 0;
        rd_idx_q.delete(); rd_col_q.delete(); rd_last_q.delete(); rd_cyc_q.delete();
        inc_cnt = 0; done_cnt = 0; done_cyc = -1; post_valid = 0; post_busy = 0;
        err_c1 = 1'bx; stall_ok = 1; timed_out = 0;
        @(negedge clock);
        for (int cyc = 0; cyc < 200; cyc++) begin
            start = (cyc == 0) || (cyc == spur_cyc);
            #1;
            if (prev_stalled && !(rd_if.rd_valid && int'(rd_if.rd_idx) == s_idx &&
                                  int'(rd_if.rd_col) == s_col && int'(rd_if.rd_col_last) == s_last))
                stall_ok = 0;
            if (rd_if.rd_valid && int'(rd_if.rd_idx) == stall_idx && stall_n > 0) begin
                rd_if.rd_ready = 1'b0;
                stall_n--;
                prev_stalled = 1;
                s_idx = int'(rd_if.rd_idx); s_col = int'(rd_if.rd_col); s_last = int'(rd_if.rd_col_last);
            end else begin
                rd_if.rd_ready = 1'b1;
                prev_stalled = 0;
            end
            #1;
            if (rd_if.rd_valid && rd_if.rd_ready) begin
                rd_idx_q.push_back(int'(rd_if.rd_idx));
                rd_col_q.push_back(int'(rd_if.rd_col));
                rd_last_q.push_back(int'(rd_if.rd_col_last));
                rd_cyc_q.push_back(cyc);
            end
            if (addr_index_inc) inc_cnt++;
            if (cyc == 1) err_c1 = err;
            if (seen_done) begin
                post_valid += int'(rd_if.rd_valid);
                post_busy  += int'(busy);
                post_n++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                seen_done = 1;
            end
            if (post_n == 3) break;
            @(negedge clock);
        end
        start = 1'b0;
        rd_if.rd_ready = 1'b1;
        timed_out = !seen_done;
        err_end = err;
        if (timed_out) begin
            checks++; errors++;
            $display("FAIL pass_timeout: no done within 200 cycles");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; rd_if.rd_ready = 1'b1; spad_rewind = 1'b0;
        clear_spad();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock); #1;
        checks++;
        if ({rd_if.rd_valid, rd_if.rd_idx, rd_if.rd_col, rd_if.rd_col_last, busy, done, err, addr_index_inc} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b idx=%0d col=%0d last=%b busy=%b done=%b err=%b inc=%b expected all 0",
                     rd_if.rd_valid, rd_if.rd_idx, rd_if.rd_col, rd_if.rd_col_last, busy, done, err, addr_index_inc);
        end
    endtask

    task automatic test_two_columns();
        int ei[5] = '{0, 1, 2, 3, 4};
        int ec[5] = '{0, 0, 0, 1, 1};
        int el[5] = '{0, 0, 1, 0, 1};
        int ey[5] = '{2, 3, 4, 6, 7};
        clear_spad(); spad_mem[0] = 8'd3; spad_mem[1] = 8'd5;
        run_pass(-1, 0, -1);
        checks++;
        if (rd_idx_q.size() != 5) begin errors++; $display("FAIL t1_reads: got %0d expected 5", rd_idx_q.size()); end
        for (int i = 0; i < 5 && i < rd_idx_q.size(); i++) begin
            checks++;
            if (rd_idx_q[i] != ei[i] || rd_col_q[i] != ec[i] || rd_last_q[i] != el[i] || rd_cyc_q[i] != ey[i]) begin
                errors++;
                $display("FAIL t1_read[%0d]: got idx=%0d col=%0d last=%0d cyc=%0d expected idx=%0d col=%0d last=%0d cyc=%0d",
                         i, rd_idx_q[i], rd_col_q[i], rd_last_q[i], rd_cyc_q[i], ei[i], ec[i], el[i], ey[i]);
            end
        end
        checks++; if (inc_cnt != 3) begin errors++; $display("FAIL t1_inc: got %0d expected 3", inc_cnt); end
        checks++; if (done_cnt != 1 || done_cyc != 9) begin errors++; $display("FAIL t1_done: got cnt=%0d cyc=%0d expected cnt=1 cyc=9", done_cnt, done_cyc); end
        checks++; if (err_end !== 1'b0) begin errors++; $display("FAIL t1_err: got %b expected 0", err_end); end
        checks++; if (sidx !== 4'd0) begin errors++; $display("FAIL t1_rewind: got %0d expected 0", sidx); end
    endtask

    task automatic test_empty_column();
        int ei[4] = '{0, 1, 2, 3};
        int ec[4] = '{0, 0, 2, 2};
        int el[4] = '{0, 1, 0, 1};
        int ey[4] = '{2, 3, 6, 7};
        clear_spad(); spad_mem[0] = 8'd2; spad_mem[1] = 8'd2; spad_mem[2] = 8'd4;
        run_pass(-1, 0, -1);
        checks++;
        if (rd_idx_q.size() != 4) begin errors++; $display("FAIL t2_reads: got %0d expected 4", rd_idx_q.size()); end
        for (int i = 0; i < 4 && i < rd_idx_q.size(); i++) begin
            checks++;
            if (rd_idx_q[i] != ei[i] || rd_col_q[i] != ec[i] || rd_last_q[i] != el[i] || rd_cyc_q[i] != ey[i]) begin
                errors++;
                $display("FAIL t2_read[%0d]: got idx=%0d col=%0d last=%0d cyc=%0d expected idx=%0d col=%0d last=%0d cyc=%0d",
                         i, rd_idx_q[i], rd_col_q[i], rd_last_q[i], rd_cyc_q[i], ei[i], ec[i], el[i], ey[i]);
            end
        end
        checks++; if (inc_cnt != 4) begin errors++; $display("FAIL t2_inc: got %0d expected 4", inc_cnt); end
        checks++; if (done_cnt != 1 || done_cyc != 9) begin errors++; $display("FAIL t2_done: got cnt=%0d cyc=%0d expected cnt=1 cyc=9", done_cnt, done_cyc); end
        checks++; if (sidx !== 4'd0) begin errors++; $display("FAIL t2_rewind: got %0d expected 0", sidx); end
    endtask

    task automatic test_backpressure();
        clear_spad(); spad_mem[0] = 8'd3;
        run_pass(1, 2, -1);
        checks++;
        if (rd_idx_q.size() != 3) begin errors++; $display("FAIL t3_handshakes: got %0d expected 3", rd_idx_q.size()); end
        for (int i = 0; i < 3 && i < rd_idx_q.size(); i++) begin
            checks++;
            if (rd_idx_q[i] != i) begin errors++; $display("FAIL t3_idx[%0d]: got %0d expected %0d", i, rd_idx_q[i], i); end
        end
        checks++; if (!stall_ok) begin errors++; $display("FAIL t3_stable: request changed while stalled, expected held"); end
        checks++;
        if (rd_cyc_q.size() > 1 && rd_cyc_q[1] != 5) begin errors++; $display("FAIL t3_stall_cyc: got %0d expected 5", rd_cyc_q[1]); end
        checks++; if (done_cyc != 8 || inc_cnt != 2) begin errors++; $display("FAIL t3_done: got cyc=%0d inc=%0d expected cyc=8 inc=2", done_cyc, inc_cnt); end
    endtask

    task automatic test_format_error();
        clear_spad(); spad_mem[0] = 8'd4; spad_mem[1] = 8'd2;
        run_pass(-1, 0, -1);
        checks++;
        if (rd_idx_q.size() != 4 || rd_idx_q[3] != 3 || rd_last_q[3] != 1) begin
            errors++;
            $display("FAIL t4_reads: got n=%0d expected n=4 ending idx=3 last=1", rd_idx_q.size());
        end
        checks++; if (err_end !== 1'b1) begin errors++; $display("FAIL t4_err: got %b expected 1", err_end); end
        checks++; if (done_cnt != 1 || done_cyc != 7) begin errors++; $display("FAIL t4_done: got cnt=%0d cyc=%0d expected cnt=1 cyc=7", done_cnt, done_cyc); end
        checks++; if (post_valid != 0) begin errors++; $display("FAIL t4_post_reads: got %0d expected 0", post_valid); end
        checks++; if (inc_cnt != 1 || sidx !== 4'd1) begin errors++; $display("FAIL t4_no_inc: got inc=%0d sidx=%0d expected inc=1 sidx=1", inc_cnt, sidx); end
        // The next start must clear the sticky error.
        @(negedge clock); spad_rewind = 1'b1;
        @(negedge clock); spad_rewind = 1'b0;
        clear_spad(); spad_mem[0] = 8'd3;
        run_pass(-1, 0, -1);
        checks++; if (err_c1 !== 1'b0 || err_end !== 1'b0) begin errors++; $display("FAIL t4_err_clear: got c1=%b end=%b expected 0 0", err_c1, err_end); end
        checks++; if (rd_idx_q.size() != 3) begin errors++; $display("FAIL t4_recover_reads: got %0d expected 3", rd_idx_q.size()); end
    endtask

    task automatic test_reset_mid_pass();
        bit hit = 0;
        clear_spad(); spad_mem[0] = 8'd6;
        @(negedge clock);
        for (int cyc = 0; cyc < 20; cyc++) begin
            start = (cyc == 0);
            #2;
            if (rd_if.rd_valid && rd_if.rd_idx == 4'd2) begin
                reset = 1'b1;
                hit = 1;
                break;
            end
            @(negedge clock);
        end
        start = 1'b0;
        checks++; if (!hit) begin errors++; $display("FAIL t5_reach_idx2: got no idx 2 expected idx 2 within 20 cycles"); end
        @(negedge clock); #2;
        checks++;
        if (busy !== 1'b0 || rd_if.rd_valid !== 1'b0 || done !== 1'b0 || sidx !== 4'd0) begin
            errors++;
            $display("FAIL t5_after_reset: got busy=%b valid=%b done=%b sidx=%0d expected 0 0 0 0", busy, rd_if.rd_valid, done, sidx);
        end
        reset = 1'b0;
        run_pass(-1, 0, -1);
        checks++;
        if (rd_idx_q.size() != 6) begin errors++; $display("FAIL t5_replay_n: got %0d expected 6", rd_idx_q.size()); end
        for (int i = 0; i < 6 && i < rd_idx_q.size(); i++) begin
            checks++;
            if (rd_idx_q[i] != i || rd_col_q[i] != 0 || rd_last_q[i] != int'(i == 5)) begin
                errors++;
                $display("FAIL t5_replay[%0d]: got idx=%0d col=%0d last=%0d expected idx=%0d col=0 last=%0d",
                         i, rd_idx_q[i], rd_col_q[i], rd_last_q[i], i, int'(i == 5));
            end
        end
        checks++; if (done_cyc != 9) begin errors++; $display("FAIL t5_done: got cyc=%0d expected 9", done_cyc); end
    endtask

    task automatic test_back_to_back();
        int a_n, a_idx, a_last, a_cyc, a_inc, a_done;
        clear_spad(); spad_mem[0] = 8'd1;
        run_pass(-1, 0, 1);
        a_n = rd_idx_q.size();
        a_idx = (a_n > 0) ? rd_idx_q[0] : -1;
        a_last = (a_n > 0) ? rd_last_q[0] : -1;
        a_cyc = (a_n > 0) ? rd_cyc_q[0] : -1;
        a_inc = inc_cnt; a_done = done_cyc;
        checks++;
        if (a_n != 1 || a_idx != 0 || a_last != 1 || a_cyc != 2 || a_inc != 2 || a_done != 4) begin
            errors++;
            $display("FAIL t6_pass_a: got n=%0d idx=%0d last=%0d cyc=%0d inc=%0d done=%0d expected 1 0 1 2 2 4",
                     a_n, a_idx, a_last, a_cyc, a_inc, a_done);
        end
        run_pass(-1, 0, 4);
        checks++;
        if (rd_idx_q.size() != 1 || rd_idx_q[0] != 0 || rd_last_q[0] != 1 || rd_cyc_q[0] != 2 || inc_cnt != 2 || done_cyc != 4) begin
            errors++;
            $display("FAIL t6_pass_b: got n=%0d inc=%0d done=%0d expected n=1 idx=0 last=1 cyc=2 inc=2 done=4",
                     rd_idx_q.size(), inc_cnt, done_cyc);
        end
        checks++; if (post_busy != 0 || post_valid != 0) begin errors++; $display("FAIL t6_start_in_done: got busy=%0d valid=%0d expected 0 0", post_busy, post_valid); end
        checks++; if (sidx !== 4'd0) begin errors++; $display("FAIL t6_rewind: got %0d expected 0", sidx); end
    endtask

    initial begin
        test_reset();
        test_two_columns();
        test_empty_column();
        test_backpressure();
        test_format_error();
        test_reset_mid_pass();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
